// File: rtl/decoder_8b10b_sync_ctrl_if.sv
// Signal bundle between the deserializer/decoder side and the word-alignment
// and link-sync controller. Suffixes are from the controller's point of view:
// _i are driven toward the controller, _o are driven by it.
interface decoder_8b10b_sync_ctrl_if;
    logic [9:0]  raw_word_i;     // deserializer word, bit0 = a ... bit9 = j
    logic        raw_valid_i;    // raw_word_i qualifier
    logic        dec_valid_i;    // decoder dout_valid
    logic        dec_ctrl_i;     // decoder ctrldetect
    logic        dec_err_i;      // decoder errdetect
    logic        dec_disperr_i;  // decoder disperr
    logic        err_clr_i;      // clears err_count_o when the counter is built
    logic        bitslip_o;      // one-cycle slip request to the deserializer
    logic        dec_rst_o;      // synchronous reset request to the decoder
    logic        sync_ok_o;      // link aligned and in sync
    logic [3:0]  slip_cnt_o;     // current bit offset, 0..9
    logic [15:0] err_count_o;    // saturating decode-error count

    // Source side: deserializer, decoder and error-clear control
    modport master (
        output raw_word_i, raw_valid_i, dec_valid_i, dec_ctrl_i,
               dec_err_i, dec_disperr_i, err_clr_i,
        input  bitslip_o, dec_rst_o, sync_ok_o, slip_cnt_o, err_count_o
    );

    // Controller side
    modport slave (
        input  raw_word_i, raw_valid_i, dec_valid_i, dec_ctrl_i,
               dec_err_i, dec_disperr_i, err_clr_i,
        output bitslip_o, dec_rst_o, sync_ok_o, slip_cnt_o, err_count_o
    );
endinterface

// File: rtl/decoder_8b10b_sync_ctrl.sv
// Word-alignment and link-sync controller for the 8B/10B receive decoder.
// Hunts for commas in raw deserializer words, steers alignment with bitslip
// pulses, resets the decoder after every realignment, and qualifies lock from
// decoder status with an error-credit hysteresis.
// Optional build macro: SYNC_ERR_CNT_EN adds the saturating err_count
// counter; without it err_count is tied to zero and err_clr is ignored.
module decoder_8b10b_sync_ctrl #(
    parameter int SEARCH_LEN  = 16,  // raw words without a comma before a slip
    parameter int SLIP_WAIT   = 4,   // raw words dropped after a slip
    parameter int DEC_RST_LEN = 2,   // cycles dec_rst is held per request
    parameter int ACQ_COMMAS  = 3,   // consecutive decoded commas to lock
    parameter int ERR_MAX     = 4,   // error credit that drops lock
    parameter int GOOD_RUN    = 4    // good words that repay one credit
) (
    input  logic                            clk,
    input  logic                            reset,
    decoder_8b10b_sync_ctrl_if.slave        bus
);

    localparam int SRCH_W = $clog2(SEARCH_LEN + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int RST_W  = $clog2(DEC_RST_LEN + 1);
    localparam int GOOD_W = $clog2(ACQ_COMMAS + 1);
    localparam int CRED_W = $clog2(ERR_MAX + 1);
    localparam int RUN_W  = $clog2(GOOD_RUN + 1);

    localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_FULL = WAIT_W'(SLIP_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(DEC_RST_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(ACQ_COMMAS - 1);
    localparam logic [CRED_W-1:0] CRED_LAST = CRED_W'(ERR_MAX - 1);
    localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(GOOD_RUN);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(GOOD_RUN - 1);

    typedef enum logic [2:0] {
        LOSS   = 3'd0,
        HUNT   = 3'd1,
        SETTLE = 3'd2,
        ACQ    = 3'd3,
        SYNC   = 3'd4
    } state_t;

    // Bit offset advances 0..9 and wraps, one step per slip.
    function automatic logic [3:0] next_offset(input logic [3:0] cur);
        return (cur == 4'd9) ? 4'd0 : cur + 4'd1;
    endfunction

    state_t              state_q, state_d;
    logic [SRCH_W-1:0]   search_q, search_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [RST_W-1:0]    rcnt_q, rcnt_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [CRED_W-1:0]   credit_q, credit_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [3:0]          slip_cnt_q, slip_cnt_d;
    logic                bitslip_q, bitslip_d;
    logic                dec_rst_q, dec_rst_d;
    logic                sync_ok_q, sync_ok_d;

    // Comma check on {a,b,c,d,e,i,f}; j/h/g do not take part.
    logic [6:0] comma_pat;
    logic       is_comma;
    logic       unused_raw_hi;

    assign comma_pat     = {bus.raw_word_i[0], bus.raw_word_i[1], bus.raw_word_i[2],
                            bus.raw_word_i[3], bus.raw_word_i[4], bus.raw_word_i[5],
                            bus.raw_word_i[6]};
    assign is_comma      = bus.raw_valid_i &&
                           ((comma_pat == 7'b0011111) || (comma_pat == 7'b1100000));
    assign unused_raw_hi = ^bus.raw_word_i[9:7];

    // Event decodes shared by next-state and datapath logic.
    logic rst_last;     // dec_rst drops at the coming edge
    logic rst_free;     // dec_rst is low from the coming edge on
    logic slip_now;     // SEARCH_LEN-th word in HUNT: slip beats any comma
    logic comma_now;
    logic settle_done;
    logic acq_err;
    logic acq_good;
    logic acq_done;
    logic bad_word;
    logic sync_lost;

    assign rst_last    = dec_rst_q && (rcnt_q == RST_LAST);
    assign rst_free    = !dec_rst_q || (rcnt_q == RST_LAST);
    assign slip_now    = bus.raw_valid_i && (search_q == SRCH_LAST);
    assign comma_now   = is_comma && !slip_now;
    assign settle_done = ((wait_q == WAIT_FULL) ||
                          (bus.raw_valid_i && (wait_q == WAIT_LAST))) && rst_free;
    assign acq_err     = bus.dec_valid_i && bus.dec_err_i;
    assign acq_good    = bus.dec_valid_i && bus.dec_ctrl_i && !bus.dec_err_i;
    assign acq_done    = acq_good && (good_q == GOOD_LAST);
    assign bad_word    = bus.dec_valid_i && (bus.dec_err_i || bus.dec_disperr_i);
    assign sync_lost   = bad_word && (credit_q == CRED_LAST);

    // State register; reset lands in LOSS so the decoder is reset first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOSS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection for the alignment / lock FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOSS:    if (rst_last)    state_d = HUNT;
            HUNT: begin
                if (slip_now)         state_d = SETTLE;
                else if (comma_now)   state_d = ACQ;
            end
            SETTLE:  if (settle_done) state_d = HUNT;
            ACQ: begin
                if (acq_err)          state_d = HUNT;
                else if (acq_done)    state_d = SYNC;
            end
            SYNC:    if (sync_lost)   state_d = LOSS;
            default:                  state_d = LOSS;
        endcase
    end

    // Per-state counter updates and registered output requests.
    always_comb begin
        bitslip_d  = 1'b0;
        dec_rst_d  = dec_rst_q;
        rcnt_d     = rcnt_q;
        search_d   = search_q;
        wait_d     = wait_q;
        good_d     = good_q;
        credit_d   = credit_q;
        run_d      = run_q;
        slip_cnt_d = slip_cnt_q;
        sync_ok_d  = (state_d == SYNC);

        // dec_rst pulse timer, shared by LOSS and SETTLE
        if (dec_rst_q) begin
            if (rcnt_q == RST_LAST) begin
                dec_rst_d = 1'b0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end

        case (state_q)
            LOSS: begin
                if (rst_last) begin
                    search_d = '0;
                end
            end
            HUNT: begin
                if (bus.raw_valid_i) begin
                    search_d = search_q + 1'b1;
                end
                if (slip_now) begin
                    bitslip_d  = 1'b1;
                    dec_rst_d  = 1'b1;
                    rcnt_d     = '0;
                    wait_d     = '0;
                    search_d   = '0;
                    slip_cnt_d = next_offset(slip_cnt_q);
                end else if (comma_now) begin
                    good_d = '0;
                end
            end
            SETTLE: begin
                // Words here come from a deserializer that is still settling
                if (bus.raw_valid_i && (wait_q != WAIT_FULL)) begin
                    wait_d = wait_q + 1'b1;
                end
                if (settle_done) begin
                    search_d = '0;
                end
            end
            ACQ: begin
                // Disparity is not checked: the decoder restarts at RD- after dec_rst
                if (acq_good) begin
                    if (acq_done) begin
                        credit_d = '0;
                        run_d    = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end else if (bus.dec_valid_i && !bus.dec_err_i) begin
                    good_d = '0;
                end
            end
            SYNC: begin
                if (bad_word) begin
                    credit_d = credit_q + 1'b1;
                    run_d    = '0;
                    if (sync_lost) begin
                        dec_rst_d = 1'b1;
                        rcnt_d    = '0;
                    end
                end else if (bus.dec_valid_i) begin
                    if ((run_q == RUN_LAST) && (credit_q != '0)) begin
                        credit_d = credit_q - 1'b1;
                        run_d    = '0;
                    end else if (run_q != RUN_FULL) begin
                        run_d = run_q + 1'b1;
                    end
                end
            end
            default: begin
                dec_rst_d = 1'b1;
                rcnt_d    = '0;
            end
        endcase
    end

    // Counter and output registers; all abandon in-flight work on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            search_q   <= '0;
            wait_q     <= '0;
            rcnt_q     <= '0;
            good_q     <= '0;
            credit_q   <= '0;
            run_q      <= '0;
            slip_cnt_q <= 4'd0;
            bitslip_q  <= 1'b0;
            dec_rst_q  <= 1'b1;
            sync_ok_q  <= 1'b0;
        end else begin
            search_q   <= search_d;
            wait_q     <= wait_d;
            rcnt_q     <= rcnt_d;
            good_q     <= good_d;
            credit_q   <= credit_d;
            run_q      <= run_d;
            slip_cnt_q <= slip_cnt_d;
            bitslip_q  <= bitslip_d;
            dec_rst_q  <= dec_rst_d;
            sync_ok_q  <= sync_ok_d;
        end
    end

    assign bus.bitslip_o  = bitslip_q;
    assign bus.dec_rst_o  = dec_rst_q;
    assign bus.sync_ok_o  = sync_ok_q;
    assign bus.slip_cnt_o = slip_cnt_q;

`ifdef SYNC_ERR_CNT_EN
    // Count saturates instead of wrapping so a long burst never reads as clean.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] err_count_q, err_count_d;

    // Bad decoded words outside LOSS bump the count; clear has priority.
    always_comb begin
        err_count_d = err_count_q;
        if (bus.err_clr_i) begin
            err_count_d = 16'h0000;
        end else if ((state_q != LOSS) && bad_word) begin
            err_count_d = sat_inc16(err_count_q);
        end
    end

    // Error count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= 16'h0000;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign bus.err_count_o = err_count_q;
`else
    logic unused_err_clr;
    assign unused_err_clr  = bus.err_clr_i;
    assign bus.err_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_decoder_8b10b_sync_ctrl.sv
// Directed bench for decoder_8b10b_sync_ctrl: a per-cycle vector table covers
// reset, acquisition, credit hysteresis, loss of sync and the error counter;
// hand sequences cover slip spacing, offset wrap and reset during SETTLE.
module tb_decoder_8b10b_sync_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decoder_8b10b_sync_ctrl_if bus_if ();

    decoder_8b10b_sync_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

`ifdef SYNC_ERR_CNT_EN
    localparam bit ECNT = 1'b1;
`else
    localparam bit ECNT = 1'b0;
`endif
    localparam logic [9:0] K285 = 10'h17C;   // abcdeifghj = 0011111010
    localparam logic [9:0] DW   = 10'h000;   // never a comma

    typedef struct packed {
        logic        rv;
        logic [9:0]  rw;
        logic        dv, dc, de, dd, clr;
        logic        bs, dr, so;
        logic [3:0]  sc;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[$];
    int   nvec, nfail;
    int   m;            // bench deserializer misalignment, 0 = aligned
    bit   auto_on;
    int   cyc_n, n_slips, rst_chk;
    int   slip_at[$];
    bit   prev_bs;

    function automatic vec_t mk(input logic rv, input logic [9:0] rw, input logic dv,
                                input logic dc, input logic de, input logic dd,
                                input logic clr, input logic bs, input logic dr,
                                input logic so, input logic [3:0] sc, input int ec);
        vec_t v;
        v.rv = rv; v.rw = rw; v.dv = dv; v.dc = dc; v.de = de; v.dd = dd; v.clr = clr;
        v.bs = bs; v.dr = dr; v.so = so; v.sc = sc;
        v.ec = ECNT ? 16'(ec) : 16'h0000;
        return v;
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] k, input int s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = k[(i + s) % 10];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus_if.raw_valid_i   = 1'b0;
        bus_if.raw_word_i    = DW;
        bus_if.dec_valid_i   = 1'b0;
        bus_if.dec_ctrl_i    = 1'b0;
        bus_if.dec_err_i     = 1'b0;
        bus_if.dec_disperr_i = 1'b0;
        bus_if.err_clr_i     = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        bus_if.raw_valid_i   = v.rv;
        bus_if.raw_word_i    = v.rw;
        bus_if.dec_valid_i   = v.dv;
        bus_if.dec_ctrl_i    = v.dc;
        bus_if.dec_err_i     = v.de;
        bus_if.dec_disperr_i = v.dd;
        bus_if.err_clr_i     = v.clr;
    endtask

    // Aligned K28.5 stream and a decoder that flags every misaligned word
    task automatic drive_auto();
        bus_if.raw_valid_i   = 1'b1;
        bus_if.raw_word_i    = rot(K285, m);
        bus_if.dec_valid_i   = 1'b1;
        bus_if.dec_ctrl_i    = (m == 0);
        bus_if.dec_err_i     = (m != 0);
        bus_if.dec_disperr_i = 1'b0;
        bus_if.err_clr_i     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cyc_n = 0; n_slips = 0; rst_chk = 0; prev_bs = 1'b0;
        slip_at.delete();
    endtask

    // One clock; watches slip pulses and the dec_rst window that follows each
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        if (bus_if.bitslip_o) begin
            chk("bitslip_not_back_to_back", prev_bs, 0);
            chk("dec_rst_with_slip", bus_if.dec_rst_o, 1);
            n_slips++;
            slip_at.push_back(cyc_n);
            rst_chk = 2;
            if (auto_on) m = (m + 9) % 10;
        end else if (rst_chk == 2) begin
            chk("dec_rst_2nd_cycle", bus_if.dec_rst_o, 1);
            rst_chk = 1;
        end else if (rst_chk == 1) begin
            chk("dec_rst_released", bus_if.dec_rst_o, 0);
            rst_chk = 0;
        end
        prev_bs = bus_if.bitslip_o;
        if (auto_on) drive_auto();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0; nfail = 0; m = 0; auto_on = 1'b0;
        reset = 1'b1;

        // rv rw dv dc de dd clr | bitslip dec_rst sync_ok slip_cnt err_count
        tbl.push_back(mk(0, DW,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // LOSS, dec_rst 1st
        tbl.push_back(mk(0, DW,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // dec_rst done -> HUNT
        tbl.push_back(mk(1, K285, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // comma -> ACQ
        tbl.push_back(mk(0, DW,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // good 1
        tbl.push_back(mk(0, DW,   1, 1, 0, 1, 0, 0, 0, 0, 0, 1)); // good 2, disperr ignored
        tbl.push_back(mk(0, DW,   1, 1, 0, 0, 0, 0, 0, 1, 0, 1)); // 3rd comma -> SYNC
        tbl.push_back(mk(0, DW,   0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, DW,   1, 0, 1, 0, 0, 0, 0, 1, 0, 2)); // credit 1
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, DW, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, DW,   1, 0, 0, 1, 0, 0, 0, 1, 0, 3)); // disperr, credit 1
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, DW, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, DW,   1, 0, 1, 0, 0, 0, 0, 1, 0, 4)); // credit 1
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, DW, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, DW,   1, 0, 1, 0, 0, 0, 0, 1, 0, 5)); // credit 1
        tbl.push_back(mk(0, DW,   1, 0, 1, 0, 0, 0, 0, 1, 0, 6)); // credit 2
        tbl.push_back(mk(0, DW,   1, 0, 1, 0, 0, 0, 0, 1, 0, 7)); // credit 3
        tbl.push_back(mk(0, DW,   1, 0, 1, 0, 0, 0, 1, 0, 0, 8)); // credit 4 -> LOSS
        tbl.push_back(mk(0, DW,   0, 0, 0, 0, 0, 0, 1, 0, 0, 8));
        tbl.push_back(mk(0, DW,   0, 0, 0, 0, 0, 0, 0, 0, 0, 8)); // -> HUNT
        tbl.push_back(mk(0, DW,   0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // err_clr
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, DW, 1, 0, 1, 0, 0, 0, 0, 0, 0, i));
        tbl.push_back(mk(0, DW,   1, 0, 1, 0, 1, 0, 0, 0, 0, 0)); // clr beats increment
        tbl.push_back(mk(0, DW,   1, 0, 0, 1, 0, 0, 0, 0, 0, 1)); // disperr counts in HUNT

        // Reset values, then the table
        do_reset();
        chk("reset_bitslip",  bus_if.bitslip_o,   0);
        chk("reset_dec_rst",  bus_if.dec_rst_o,   1);
        chk("reset_sync_ok",  bus_if.sync_ok_o,   0);
        chk("reset_slip_cnt", bus_if.slip_cnt_o,  0);
        chk("reset_err_cnt",  bus_if.err_count_o, 0);
        foreach (tbl[i]) begin
            apply(tbl[i]);
            cyc();
            chk($sformatf("v%0d_bitslip", i),  bus_if.bitslip_o,   tbl[i].bs);
            chk($sformatf("v%0d_dec_rst", i),  bus_if.dec_rst_o,   tbl[i].dr);
            chk($sformatf("v%0d_sync_ok", i),  bus_if.sync_ok_o,   tbl[i].so);
            chk($sformatf("v%0d_slip_cnt", i), bus_if.slip_cnt_o,  tbl[i].sc);
            chk($sformatf("v%0d_err_cnt", i),  bus_if.err_count_o, tbl[i].ec);
        end

        // Stream 3 bits off: three slips, 16 + 4 words apart
        do_reset();
        m = 3; auto_on = 1'b1; drive_auto();
        repeat (120) cyc();
        auto_on = 1'b0; idle();
        chk("off3_slip_count", n_slips, 3);
        if (slip_at.size() >= 3) begin
            chk("off3_first_slip_cycle", slip_at[0], 18);
            chk("off3_slip_gap1", slip_at[1] - slip_at[0], 20);
            chk("off3_slip_gap2", slip_at[2] - slip_at[1], 20);
        end
        chk("off3_slip_cnt", bus_if.slip_cnt_o, 3);
        chk("off3_sync_ok",  bus_if.sync_ok_o, 1);

        // Offset 9, then one forced slip wraps the offset to 0
        do_reset();
        m = 9; auto_on = 1'b1; drive_auto();
        repeat (220) cyc();
        auto_on = 1'b0; idle();
        chk("off9_slip_count", n_slips, 9);
        chk("off9_slip_cnt", bus_if.slip_cnt_o, 9);
        chk("off9_sync_ok",  bus_if.sync_ok_o, 1);
        bus_if.dec_valid_i = 1'b1; bus_if.dec_err_i = 1'b1;
        repeat (4) cyc();
        idle();
        chk("off9_lost_sync", bus_if.sync_ok_o, 0);
        n_slips = 0;
        bus_if.raw_valid_i = 1'b1; bus_if.raw_word_i = DW;
        for (int k = 0; k < 40 && n_slips == 0; k++) cyc();
        idle();
        chk("wrap_slip_seen", n_slips, 1);
        chk("wrap_slip_cnt",  bus_if.slip_cnt_o, 0);

        // Reset asserted in SETTLE takes effect before the next clock edge
        do_reset();
        bus_if.raw_valid_i = 1'b1; bus_if.raw_word_i = DW;
        for (int k = 0; k < 40 && n_slips == 0; k++) cyc();
        chk("settle_slip_seen", n_slips, 1);
        chk("settle_slip_cnt",  bus_if.slip_cnt_o, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_bitslip",  bus_if.bitslip_o,  0);
        chk("async_rst_dec_rst",  bus_if.dec_rst_o,  1);
        chk("async_rst_sync_ok",  bus_if.sync_ok_o,  0);
        chk("async_rst_slip_cnt", bus_if.slip_cnt_o, 0);
        idle();
        @(posedge clk);
        #1 reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
